reg_file_scoreboard: RTL and testbench

- Parametrised successor to the processor's register file.
- Storage is configurable in width and depth, with two combinational read ports and one synchronous write port.
- Optional write-through bypass.
- Per-register pending-write scoreboard lets the 4-stage pipeline detect RAW hazards and stall decode until the producing instruction writes back.
- Sits between decode (read/issue) and writeback (write).

---
 rtl/reg_file_scoreboard.sv | 145 ++++++++++++++
 tb/tb_reg_file_scoreboard.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_file_scoreboard
// Parametrised register file with a per-register pending-write scoreboard.
// Decode reads two operands combinationally and marks the destination of the
// issuing instruction pending. Writeback stores the result and clears the
// pending bit. A RAW hazard on a consumed operand raises stall_out.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-high reset
//   read_reg_1/2, use_1/2         operand addresses and "operand consumed"
//   read_data_1/2                 operand data (combinational)
//   read_pending_1/2              operand has an outstanding producer
//   stall_out                     consumed operand is pending
//   issue_reg, issue_enable       mark a destination pending
//   write_reg, write_data,
//   write_enable                  writeback port
//   pending_count                 registered number of pending registers
// ---------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] read_reg_1,
    input  logic [ADDR_BITS-1:0] read_reg_2,
    input  logic                 use_1,
    input  logic                 use_2,
    output logic [WIDTH-1:0]     read_data_1,
    output logic [WIDTH-1:0]     read_data_2,
    output logic                 read_pending_1,
    output logic                 read_pending_2,
    output logic                 stall_out,
    input  logic [ADDR_BITS-1:0] issue_reg,
    input  logic                 issue_enable,
    input  logic [ADDR_BITS-1:0] write_reg,
    input  logic [WIDTH-1:0]     write_data,
    input  logic                 write_enable,
    output logic [ADDR_BITS:0]   pending_count
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] ZERO_ADDR = {ADDR_BITS{1'b0}};

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [DEPTH-1:0]     pending_r;
    logic [ADDR_BITS:0]   count_r;

    logic                 write_ok_s;
    logic                 issue_ok_s;
    logic                 rise_s;
    logic                 fall_s;
    logic [DEPTH-1:0]     pending_nxt_s;
    logic [ADDR_BITS:0]   count_nxt_s;

    logic [ADDR_BITS-1:0] rd_addr_s     [2];
    logic [WIDTH-1:0]     rd_data_s     [2];
    logic [1:0]           rd_pending_s;
    logic [1:0]           zero_hit_s;
    logic [1:0]           bypass_hit_s;

    // Writes and issues are dropped while reset is high and when they target
    // the hardwired zero register, so neither can disturb state or forward.
    assign write_ok_s = write_enable & ~reset &
                        ~((ZERO_REG != 0) && (write_reg == ZERO_ADDR));
    assign issue_ok_s = issue_enable & ~reset &
                        ~((ZERO_REG != 0) && (issue_reg == ZERO_ADDR));

    // A 0->1 transition only comes from an issue; a 1->0 transition only from
    // a write that is not overridden by an issue to the same register.
    assign rise_s = issue_ok_s & ~pending_r[issue_reg];
    assign fall_s = write_ok_s & pending_r[write_reg] &
                    ~(issue_ok_s & (issue_reg == write_reg));

    // Next pending vector: issue takes priority over a same-register write.
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_ok_s && (issue_reg == ADDR_BITS'(i))) begin
                pending_nxt_s[i] = 1'b1;
            end else if (write_ok_s && (write_reg == ADDR_BITS'(i))) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
    end

    assign count_nxt_s = count_r + {{ADDR_BITS{1'b0}}, rise_s}
                                 - {{ADDR_BITS{1'b0}}, fall_s};

    assign rd_addr_s[0] = read_reg_1;
    assign rd_addr_s[1] = read_reg_2;

    // Operand resolution, identical for both ports: zero reg, then forwarded
    // writeback data, then stored value.
    always_comb begin
        rd_data_s[0]  = {WIDTH{1'b0}};
        rd_data_s[1]  = {WIDTH{1'b0}};
        rd_pending_s  = 2'b00;
        zero_hit_s    = 2'b00;
        bypass_hit_s  = 2'b00;
        for (int p = 0; p < 2; p++) begin
            zero_hit_s[p]   = (ZERO_REG != 0) && (rd_addr_s[p] == ZERO_ADDR);
            bypass_hit_s[p] = (BYPASS != 0) && write_ok_s &&
                              (write_reg == rd_addr_s[p]);
            if (zero_hit_s[p]) begin
                rd_data_s[p]    = {WIDTH{1'b0}};
                rd_pending_s[p] = 1'b0;
            end else if (bypass_hit_s[p]) begin
                rd_data_s[p]    = write_data;
                rd_pending_s[p] = 1'b0;
            end else begin
                rd_data_s[p]    = mem_r[rd_addr_s[p]];
                rd_pending_s[p] = pending_r[rd_addr_s[p]];
            end
        end
    end

    assign read_data_1    = rd_data_s[0];
    assign read_data_2    = rd_data_s[1];
    assign read_pending_1 = rd_pending_s[0];
    assign read_pending_2 = rd_pending_s[1];
    assign stall_out      = (use_1 & rd_pending_s[0]) | (use_2 & rd_pending_s[1]);
    assign pending_count  = count_r;

    // Storage, scoreboard bits and pending counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            pending_r <= {DEPTH{1'b0}};
            count_r   <= {(ADDR_BITS + 1){1'b0}};
        end else begin
            if (write_ok_s) begin
                mem_r[write_reg] <= write_data;
            end
            pending_r <= pending_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;
    localparam int W  = 16;
    localparam int AB = 3;
    localparam int N  = 8;

    logic          clock;
    logic          reset;
    logic [AB-1:0] read_reg_1, read_reg_2, issue_reg, write_reg;
    logic          use_1, use_2, issue_enable, write_enable;
    logic [W-1:0]  write_data;

    logic [W-1:0]  rd1_b_s, rd2_b_s, rd1_n_s, rd2_n_s;
    logic          rp1_b_s, rp2_b_s, st_b_s, rp1_n_s, rp2_n_s, st_n_s;
    logic [AB:0]   cnt_b_s, cnt_n_s;

    reg_file_scoreboard #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clock(clock), .reset(reset),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .use_1(use_1), .use_2(use_2),
        .read_data_1(rd1_b_s), .read_data_2(rd2_b_s),
        .read_pending_1(rp1_b_s), .read_pending_2(rp2_b_s),
        .stall_out(st_b_s),
        .issue_reg(issue_reg), .issue_enable(issue_enable),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .pending_count(cnt_b_s)
    );

    reg_file_scoreboard #(.WIDTH(W), .ADDR_BITS(AB), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clock(clock), .reset(reset),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .use_1(use_1), .use_2(use_2),
        .read_data_1(rd1_n_s), .read_data_2(rd2_n_s),
        .read_pending_1(rp1_n_s), .read_pending_2(rp2_n_s),
        .stall_out(st_n_s),
        .issue_reg(issue_reg), .issue_enable(issue_enable),
        .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
        .pending_count(cnt_n_s)
    );

    typedef struct {
        logic [W-1:0] d1b, d2b, d1n, d2n;
        logic         p1b, p2b, sb, p1n, p2n, sn;
        int           cnt;
    } exp_t;

    exp_t     exp_q[$];
    int       vectors = 0;
    int       miscompares = 0;
    int       cycle_no = 0;

    // Reference state: plain arrays of register values and pending flags.
    logic [W-1:0] ref_mem [N];
    bit           ref_pend [N];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_no, act, exp);
        end
    endtask

    function automatic int popcount_ref();
        int c = 0;
        for (int i = 0; i < N; i++) c += ref_pend[i] ? 1 : 0;
        return c;
    endfunction

    // Expected operand for one port of one instance, straight from the read rules.
    task automatic ref_read(input int a, input bit byp, input bit we_v, input int wr_v,
                            input logic [W-1:0] wd_v,
                            output logic [W-1:0] d, output logic p);
        if (a == 0) begin
            d = '0; p = 1'b0;
        end else if (byp && we_v && wr_v == a) begin
            d = wd_v; p = 1'b0;
        end else begin
            d = ref_mem[a]; p = ref_pend[a];
        end
    endtask

    // Drive one cycle of stimulus, queue its expected response, then advance the model.
    task automatic step(input bit rst_v, input int a1, input int a2, input bit u1, input bit u2,
                        input int ir, input bit ie, input int wr, input logic [W-1:0] wd,
                        input bit we);
        exp_t e;
        bit   we_eff;
        @(posedge clock);
        #1;
        reset        = rst_v;
        read_reg_1   = AB'(a1);
        read_reg_2   = AB'(a2);
        use_1        = u1;
        use_2        = u2;
        issue_reg    = AB'(ir);
        issue_enable = ie;
        write_reg    = AB'(wr);
        write_data   = wd;
        write_enable = we;
        if (rst_v) begin
            for (int i = 0; i < N; i++) begin
                ref_mem[i] = '0;
                ref_pend[i] = 1'b0;
            end
        end
        we_eff = we && !rst_v;
        ref_read(a1, 1'b1, we_eff, wr, wd, e.d1b, e.p1b);
        ref_read(a2, 1'b1, we_eff, wr, wd, e.d2b, e.p2b);
        ref_read(a1, 1'b0, we_eff, wr, wd, e.d1n, e.p1n);
        ref_read(a2, 1'b0, we_eff, wr, wd, e.d2n, e.p2n);
        e.sb  = (u1 && e.p1b) || (u2 && e.p2b);
        e.sn  = (u1 && e.p1n) || (u2 && e.p2n);
        e.cnt = popcount_ref();
        exp_q.push_back(e);
        if (!rst_v) begin
            if (we && wr != 0) begin
                ref_mem[wr]  = wd;
                ref_pend[wr] = 1'b0;
            end
            if (ie && ir != 0) ref_pend[ir] = 1'b1;
        end
    endtask

    // Monitor: every cycle the DUT presents a response, compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cycle_no++;
                chk("byp_rd1",   32'(rd1_b_s), 32'(e.d1b));
                chk("byp_rd2",   32'(rd2_b_s), 32'(e.d2b));
                chk("byp_pend1", 32'(rp1_b_s), 32'(e.p1b));
                chk("byp_pend2", 32'(rp2_b_s), 32'(e.p2b));
                chk("byp_stall", 32'(st_b_s),  32'(e.sb));
                chk("byp_count", 32'(cnt_b_s), 32'(e.cnt));
                chk("nob_rd1",   32'(rd1_n_s), 32'(e.d1n));
                chk("nob_rd2",   32'(rd2_n_s), 32'(e.d2n));
                chk("nob_pend1", 32'(rp1_n_s), 32'(e.p1n));
                chk("nob_pend2", 32'(rp2_n_s), 32'(e.p2n));
                chk("nob_stall", 32'(st_n_s),  32'(e.sn));
                chk("nob_count", 32'(cnt_n_s), 32'(e.cnt));
            end
        end
    end

    initial begin
        reset = 1'b1;
        read_reg_1 = '0; read_reg_2 = '0; use_1 = 1'b0; use_2 = 1'b0;
        issue_reg = '0; issue_enable = 1'b0;
        write_reg = '0; write_data = '0; write_enable = 1'b0;

        // Directed: reset state and reads after release.
        step(1, 1, 2, 1, 1, 0, 0, 0, 16'h0000, 0);
        step(0, 1, 2, 1, 1, 0, 0, 0, 16'h0000, 0);
        // Old-vs-new value on a same-cycle write of r3.
        step(0, 3, 3, 0, 0, 0, 0, 3, 16'h0001, 1);
        step(0, 3, 3, 1, 0, 0, 0, 3, 16'h0002, 1);
        step(0, 3, 3, 1, 0, 0, 0, 0, 16'h0000, 0);
        // RAW on r5, resolved by writeback (forwarded on the bypass instance).
        step(0, 0, 0, 0, 0, 5, 1, 0, 16'h0000, 0);
        step(0, 5, 1, 1, 0, 0, 0, 0, 16'h0000, 0);
        step(0, 5, 5, 1, 1, 0, 0, 5, 16'hBEEF, 1);
        step(0, 5, 0, 1, 0, 0, 0, 0, 16'h0000, 0);
        // Zero register ignores writes and issues.
        step(0, 0, 0, 1, 1, 0, 1, 0, 16'hFFFF, 1);
        step(0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 0);
        // Same-cycle issue and write of an already-pending r7.
        step(0, 7, 7, 1, 1, 7, 1, 0, 16'h0000, 0);
        step(0, 7, 7, 1, 1, 7, 1, 7, 16'h0008, 1);
        step(0, 7, 7, 1, 1, 0, 0, 0, 16'h0000, 0);
        // Issue one register while retiring another in the same cycle.
        step(0, 7, 4, 1, 1, 4, 1, 7, 16'h0009, 1);
        step(0, 7, 4, 1, 1, 0, 0, 0, 16'h0000, 0);
        // Mid-stream reset: state written earlier must read back zero at once.
        step(0, 1, 2, 0, 0, 6, 1, 1, 16'h1234, 1);
        step(0, 1, 2, 0, 0, 0, 0, 2, 16'h5678, 1);
        step(1, 1, 2, 1, 1, 3, 1, 1, 16'hAAAA, 1);
        step(0, 1, 2, 1, 1, 0, 0, 0, 16'h0000, 0);

        // Random stream.
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(499, 0) == 0,
                 int'($urandom_range(N-1, 0)), int'($urandom_range(N-1, 0)),
                 1'($urandom), 1'($urandom),
                 int'($urandom_range(N-1, 0)), 1'($urandom),
                 int'($urandom_range(N-1, 0)), W'($urandom), 1'($urandom));
        end

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 5 && exp_q.size() > 0; t++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
